spi_arbiter: RTL and testbench
==============================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter CS_GAP, default 4: idle cycles with spi_cs_n high between transactions; legal range 1..255.
REQ-002 Parameter TIMEOUT, default 255: max cycles in WAIT per byte before abort; legal range 1..65535.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 req  in  2  per-requester transaction request; held high until done/err.
REQ-006 req_len0, req_len1  in  4 each  byte count minus 1 (0 = 1 byte, 15 = 16 bytes).
REQ-007 tx_data0, tx_data1  in  8 each  current byte to transmit per requester.
REQ-008 tx_ack  out  2  one-cycle pulse to the owner when its tx byte is consumed.
REQ-009 rx_data  out  8  last received byte.
REQ-010 rx_valid  out  2  one-hot one-cycle pulse to the owner when rx_data updates.
REQ-011 grant  out  2  one-hot current owner, 0 when idle.
REQ-012 done  out  2  one-cycle pulse to the owner at normal transaction completion.
REQ-013 err  out  2  one-cycle pulse to the owner on byte timeout.
REQ-014 spi_mosi_data  out  8  byte to SPI core.
REQ-015 spi_rdy  out  1  one-cycle start pulse to SPI core.
REQ-016 spi_cs_n  out  1  chip select to SPI core, active low.
REQ-017 spi_miso_data  in  8  byte received by SPI core.
REQ-018 spi_done  in  1  one-cycle pulse from SPI core at byte completion.

Function
REQ-019 FSM states: IDLE, SETUP, SEND, WAIT, GAP; all outputs registered.
REQ-020 IDLE, req != 0: select owner, latch its req_len, clear byte count, set grant and spi_cs_n=0 next cycle, go to SETUP.
REQ-021 Arbitration is round-robin: on both requests, grant the requester not granted most recently; last-owner resets to 1, so requester 0 wins the first tie.
REQ-022 SETUP lasts exactly 1 cycle, then SEND.
REQ-023 SEND lasts 1 cycle: spi_rdy=1, spi_mosi_data=owner's tx_data, owner's tx_ack=1, timeout counter cleared; then WAIT.
REQ-024 WAIT, spi_done=1: rx_data<=spi_miso_data and owner's rx_valid=1 next cycle; if byte count == latched len, go to GAP, else increment count and go to SEND.
REQ-025 On entry to GAP after the last byte, done pulse coincides with the final rx_valid; spi_cs_n=1 and grant=0 in the same cycle.
REQ-026 WAIT, no spi_done for TIMEOUT consecutive cycles: owner's err pulse, no done and no rx_valid, spi_cs_n=1, grant=0, go to GAP.
REQ-027 GAP holds for exactly CS_GAP cycles, then IDLE; requests are not sampled during GAP.
REQ-028 spi_done outside WAIT is ignored; spi_done and timeout in the same cycle resolve as spi_done.
REQ-029 req deasserted mid-transaction is ignored; the transaction runs to done or err.
REQ-030 req_len and tx_data changes after latch/consumption do not affect the current byte.
REQ-031 spi_cs_n stays low continuously from SETUP through the last WAIT; no mid-burst deassertion.

Reset
REQ-032 rst_n=0 at any state, including mid-transfer: next cycle state=IDLE, spi_cs_n=1, grant=0, spi_rdy=0, tx_ack=0, rx_valid=0, done=0, err=0, rx_data=0, spi_mosi_data=0, counters=0, last-owner=1.
REQ-033 A spi_done arriving after reset release is ignored; no done or err is issued for the aborted transaction.

Verification
REQ-034 req=01, req_len0=0, tx_data0=0xA5; core returns 0x3C after 10 cycles -> one spi_rdy with 0xA5, rx_data=0x3C, rx_valid=01 and done=01 same cycle, spi_cs_n high 4 cycles before IDLE.
REQ-035 req=11 simultaneous from reset -> grant=01 first; req0 held again, after done -> grant=10, then 01 (alternation).
REQ-036 req=10, req_len1=3 -> 4 spi_rdy pulses, 4 tx_ack=10, 4 rx_valid=10, spi_cs_n low throughout, done=10 once.
REQ-037 req=01, core never pulses spi_done, TIMEOUT=255 -> err=01 on the 255th WAIT cycle, no done, spi_cs_n=1, grant=0.
REQ-038 rst_n=0 during WAIT of byte 2 of 4 -> next cycle all outputs at reset values; stray spi_done afterwards produces no rx_valid.
REQ-039 req0 dropped after SEND of byte 1 of 2 -> both bytes still transferred, done=01.

Source files
------------

// File: rtl/spi_arbiter.sv
// Two-requester round-robin arbiter in front of a byte-wide SPI core.
// The owner keeps chip select for a whole burst; a fixed high gap separates bursts.
module spi_arbiter #(
  parameter int CS_GAP  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [3:0] req_len0,
  input  logic [3:0] req_len1,
  input  logic [7:0] tx_data0,
  input  logic [7:0] tx_data1,
  output logic [1:0] tx_ack,
  output logic [7:0] rx_data,
  output logic [1:0] rx_valid,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic [1:0] err,
  output logic [7:0] spi_mosi_data,
  output logic       spi_rdy,
  output logic       spi_cs_n,
  input  logic [7:0] spi_miso_data,
  input  logic       spi_done
);

  typedef enum logic [2:0] {IDLE, SETUP, SEND, WAIT, GAP} state_t;

  state_t      state, state_nx;
  logic        owner, owner_nx;
  logic        last_owner, last_owner_nx;
  logic        pick;
  logic        go_send;
  logic [1:0]  owner_oh;
  logic [3:0]  len, len_nx;
  logic [3:0]  byte_cnt, byte_cnt_nx;
  logic [15:0] tcnt, tcnt_nx;
  logic [7:0]  gcnt, gcnt_nx;

  logic [1:0]  tx_ack_nx, rx_valid_nx, grant_nx, done_nx, err_nx;
  logic [7:0]  rx_data_nx, mosi_nx;
  logic        spi_rdy_nx, spi_cs_n_nx;

  assign owner_oh = owner ? 2'b10 : 2'b01;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner         <= 1'b0;
      last_owner    <= 1'b1;
      len           <= '0;
      byte_cnt      <= '0;
      tcnt          <= '0;
      gcnt          <= '0;
      tx_ack        <= '0;
      rx_valid      <= '0;
      grant         <= '0;
      done          <= '0;
      err           <= '0;
      rx_data       <= '0;
      spi_mosi_data <= '0;
      spi_rdy       <= 1'b0;
      spi_cs_n      <= 1'b1;
    end else begin
      state         <= state_nx;
      owner         <= owner_nx;
      last_owner    <= last_owner_nx;
      len           <= len_nx;
      byte_cnt      <= byte_cnt_nx;
      tcnt          <= tcnt_nx;
      gcnt          <= gcnt_nx;
      tx_ack        <= tx_ack_nx;
      rx_valid      <= rx_valid_nx;
      grant         <= grant_nx;
      done          <= done_nx;
      err           <= err_nx;
      rx_data       <= rx_data_nx;
      spi_mosi_data <= mosi_nx;
      spi_rdy       <= spi_rdy_nx;
      spi_cs_n      <= spi_cs_n_nx;
    end
  end

  // Next-state logic; every output is the registered image of its *_nx value,
  // so outputs describe the state being entered.
  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_owner_nx = last_owner;
    len_nx        = len;
    byte_cnt_nx   = byte_cnt;
    tcnt_nx       = tcnt;
    gcnt_nx       = gcnt;
    pick          = 1'b0;
    go_send       = 1'b0;
    tx_ack_nx     = '0;
    rx_valid_nx   = '0;
    done_nx       = '0;
    err_nx        = '0;
    spi_rdy_nx    = 1'b0;
    grant_nx      = grant;
    spi_cs_n_nx   = spi_cs_n;
    rx_data_nx    = rx_data;
    mosi_nx       = spi_mosi_data;

    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          pick          = (req == 2'b11) ? ~last_owner : req[1];
          owner_nx      = pick;
          last_owner_nx = pick;
          len_nx        = pick ? req_len1 : req_len0;
          byte_cnt_nx   = '0;
          grant_nx      = pick ? 2'b10 : 2'b01;
          spi_cs_n_nx   = 1'b0;
          state_nx      = SETUP;
        end
      end
      SETUP: go_send = 1'b1;
      SEND: begin
        tcnt_nx  = '0;
        state_nx = WAIT;
      end
      WAIT: begin
        // A byte completion wins over a timeout expiring in the same cycle.
        if (spi_done) begin
          rx_data_nx  = spi_miso_data;
          rx_valid_nx = owner_oh;
          if (byte_cnt == len) begin
            done_nx     = owner_oh;
            spi_cs_n_nx = 1'b1;
            grant_nx    = '0;
            gcnt_nx     = '0;
            state_nx    = GAP;
          end else begin
            byte_cnt_nx = byte_cnt + 4'd1;
            go_send     = 1'b1;
          end
        end else if (tcnt == 16'(TIMEOUT - 1)) begin
          err_nx      = owner_oh;
          spi_cs_n_nx = 1'b1;
          grant_nx    = '0;
          gcnt_nx     = '0;
          state_nx    = GAP;
        end else begin
          tcnt_nx = tcnt + 16'd1;
        end
      end
      GAP: begin
        if (gcnt == 8'(CS_GAP - 1)) state_nx = IDLE;
        else                        gcnt_nx  = gcnt + 8'd1;
      end
      default: state_nx = IDLE;
    endcase

    if (go_send) begin
      spi_rdy_nx = 1'b1;
      mosi_nx    = owner ? tx_data1 : tx_data0;
      tx_ack_nx  = owner_oh;
      tcnt_nx    = '0;
      state_nx   = SEND;
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: a vector table of whole transactions plus
// hand-written sequences for round-robin, timeout, reset abort and req drop.
module tb_spi_arbiter;

  localparam int CS_GAP  = 4;
  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = '0;
  logic [3:0] req_len0 = '0, req_len1 = '0;
  logic [7:0] tx_data0 = '0, tx_data1 = '0;
  logic [1:0] tx_ack, rx_valid, grant, done, err;
  logic [7:0] rx_data, spi_mosi_data;
  logic       spi_rdy, spi_cs_n;
  logic [7:0] spi_miso_data;
  logic       spi_done;

  spi_arbiter #(.CS_GAP(CS_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .req_len0(req_len0), .req_len1(req_len1),
    .tx_data0(tx_data0), .tx_data1(tx_data1),
    .tx_ack(tx_ack), .rx_data(rx_data), .rx_valid(rx_valid),
    .grant(grant), .done(done), .err(err),
    .spi_mosi_data(spi_mosi_data), .spi_rdy(spi_rdy), .spi_cs_n(spi_cs_n),
    .spi_miso_data(spi_miso_data), .spi_done(spi_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [7:0] tx0;
    logic [7:0] tx1;
    logic [7:0] miso;
    int         delay;
    logic [1:0] exp_grant;
    int         exp_bytes;
    logic [7:0] exp_mosi;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs [5];

  int checks = 0, failures = 0;

  // Core model settings (main writes) and monitor counters (monitor writes).
  int         core_delay = 1;
  logic       core_en = 1'b1;
  logic [7:0] miso_base = '0;
  int cyc = 0, n_rdy = 0, n_ack0 = 0, n_ack1 = 0, n_rxv0 = 0, n_rxv1 = 0;
  int n_done0 = 0, n_done1 = 0, n_err = 0, n_glitch = 0, n_bad = 0;
  int rdy_cyc = 0, err_cyc = 0;
  logic [7:0] last_mosi = '0, last_rx = '0;
  logic [1:0] grant_at_rdy = '0, grant_at_err = '0;
  logic       cs_at_err = 1'b0;
  int s_rdy = 0, s_ack0 = 0, s_ack1 = 0, s_rxv0 = 0, s_rxv1 = 0;
  int s_done0 = 0, s_done1 = 0, s_err = 0, s_glitch = 0, s_bad = 0;

  // SPI core: answers each spi_rdy after core_delay cycles; byte k of a burst
  // returns miso_base + k.
  initial begin
    int  cnt;
    bit  pending;
    cnt = 0;
    pending = 0;
    spi_done = 1'b0;
    spi_miso_data = '0;
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (pending) begin
        if (cnt == 0) begin
          spi_done = 1'b1;
          spi_miso_data = miso_base + 8'(n_rdy - s_rdy - 1);
          pending = 0;
        end else cnt--;
      end else if (spi_rdy && core_en) begin
        pending = 1;
        cnt = core_delay - 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (spi_rdy) begin
        n_rdy++;
        rdy_cyc = cyc;
        last_mosi = spi_mosi_data;
        grant_at_rdy = grant;
      end
      if (tx_ack[0]) n_ack0++;
      if (tx_ack[1]) n_ack1++;
      if (rx_valid[0]) n_rxv0++;
      if (rx_valid[1]) n_rxv1++;
      if (rx_valid != 2'b00) last_rx = rx_data;
      if (done[0]) n_done0++;
      if (done[1]) n_done1++;
      if (done != 2'b00 && done != rx_valid) n_bad++;
      if ((grant != 2'b00) == spi_cs_n) n_glitch++;
      if (err != 2'b00) begin
        n_err++;
        err_cyc = cyc;
        grant_at_err = grant;
        cs_at_err = spi_cs_n;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic snap();
    s_rdy = n_rdy; s_ack0 = n_ack0; s_ack1 = n_ack1;
    s_rxv0 = n_rxv0; s_rxv1 = n_rxv1; s_done0 = n_done0; s_done1 = n_done1;
    s_err = n_err; s_glitch = n_glitch; s_bad = n_bad;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    checkOutput("reset_outputs",
      32'({grant, spi_cs_n, spi_rdy, tx_ack, rx_valid, done, err, rx_data, spi_mosi_data}),
      32'({2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00}));
    rst_n = 1'b1;
  endtask

  task automatic waitEnd(input int budget, output bit ok, output logic [1:0] d, output logic [1:0] e);
    ok = 0; d = '0; e = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done != 2'b00 || err != 2'b00) begin
        ok = 1; d = done; e = err;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    bit ok;
    logic [1:0] d, e;
    string tag;
    tag = $sformatf("v%0d_", idx);
    req_len0 = v.len0; req_len1 = v.len1;
    tx_data0 = v.tx0;  tx_data1 = v.tx1;
    miso_base = v.miso; core_delay = v.delay;
    snap();
    req = v.req;
    waitEnd(3000, ok, d, e);
    req = '0;
    repeat (CS_GAP + 3) @(negedge clk);
    checkOutput({tag, "finished"}, 32'(ok), 32'd1);
    checkOutput({tag, "done"}, 32'(d), 32'(v.exp_grant));
    checkOutput({tag, "grant"}, 32'(grant_at_rdy), 32'(v.exp_grant));
    checkOutput({tag, "rdy_count"}, 32'(n_rdy - s_rdy), 32'(v.exp_bytes));
    checkOutput({tag, "ack0"}, 32'(n_ack0 - s_ack0), v.exp_grant[0] ? 32'(v.exp_bytes) : 32'd0);
    checkOutput({tag, "ack1"}, 32'(n_ack1 - s_ack1), v.exp_grant[1] ? 32'(v.exp_bytes) : 32'd0);
    checkOutput({tag, "rxv0"}, 32'(n_rxv0 - s_rxv0), v.exp_grant[0] ? 32'(v.exp_bytes) : 32'd0);
    checkOutput({tag, "rxv1"}, 32'(n_rxv1 - s_rxv1), v.exp_grant[1] ? 32'(v.exp_bytes) : 32'd0);
    checkOutput({tag, "done_count"}, 32'((n_done0 - s_done0) + (n_done1 - s_done1)), 32'd1);
    checkOutput({tag, "mosi"}, 32'(last_mosi), 32'(v.exp_mosi));
    checkOutput({tag, "rx_data"}, 32'(last_rx), 32'(v.exp_rx));
    checkOutput({tag, "err_count"}, 32'(n_err - s_err), 32'd0);
    checkOutput({tag, "cs_vs_grant"}, 32'(n_glitch - s_glitch), 32'd0);
    checkOutput({tag, "done_with_rxv"}, 32'(n_bad - s_bad), 32'd0);
  endtask

  initial begin
    bit ok;
    logic [1:0] d, e;
    logic [1:0] exp_alt [3];
    int hi;

    //                req    len0   len1   tx0    tx1    miso  dly grant  bytes mosi   rx
    vecs[0] = '{2'b01, 4'd0,  4'd0, 8'hA5, 8'h00, 8'h3C, 10, 2'b01, 1,  8'hA5, 8'h3C};
    vecs[1] = '{2'b10, 4'd0,  4'd3, 8'h00, 8'h5A, 8'h10, 2,  2'b10, 4,  8'h5A, 8'h13};
    vecs[2] = '{2'b11, 4'd1,  4'd2, 8'h11, 8'h22, 8'h80, 1,  2'b01, 2,  8'h11, 8'h81};
    vecs[3] = '{2'b11, 4'd0,  4'd0, 8'h33, 8'h44, 8'hF0, 3,  2'b10, 1,  8'h44, 8'hF0};
    vecs[4] = '{2'b01, 4'd15, 4'd0, 8'hC3, 8'h00, 8'h00, 1,  2'b01, 16, 8'hC3, 8'h0F};

    repeat (2) @(negedge clk);
    applyReset();
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

    // Round-robin from reset with both requests held throughout.
    applyReset();
    exp_alt[0] = 2'b01; exp_alt[1] = 2'b10; exp_alt[2] = 2'b01;
    req_len0 = 4'd0; req_len1 = 4'd0; core_delay = 2; miso_base = 8'h55;
    snap();
    req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      waitEnd(500, ok, d, e);
      checkOutput($sformatf("rr%0d_grant", i), 32'(grant_at_rdy), 32'(exp_alt[i]));
      checkOutput($sformatf("rr%0d_done", i), 32'(d), 32'(exp_alt[i]));
      if (i < 2) begin
        hi = 1;
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (spi_cs_n) hi++;
          else break;
        end
        // CS_GAP cycles of GAP plus the IDLE cycle that samples req.
        checkOutput($sformatf("rr%0d_cs_gap", i), 32'(hi), 32'(CS_GAP + 1));
      end
    end
    req = '0;
    repeat (CS_GAP + 3) @(negedge clk);

    // Timeout: SEND cycle, TIMEOUT silent WAIT cycles, err in the next cycle.
    core_en = 1'b0;
    req_len0 = 4'd0;
    snap();
    req = 2'b01;
    waitEnd(TIMEOUT + 50, ok, d, e);
    req = '0;
    checkOutput("to_finished", 32'(ok), 32'd1);
    checkOutput("to_err", 32'(e), 32'h1);
    checkOutput("to_done", 32'(d), 32'h0);
    checkOutput("to_latency", 32'(err_cyc - rdy_cyc), 32'(TIMEOUT + 1));
    checkOutput("to_grant", 32'(grant_at_err), 32'h0);
    checkOutput("to_cs_n", 32'(cs_at_err), 32'h1);
    checkOutput("to_rxv", 32'(n_rxv0 - s_rxv0), 32'd0);
    repeat (CS_GAP + 3) @(negedge clk);
    core_en = 1'b1;

    // req0 dropped right after the first SEND; the burst still completes.
    req_len0 = 4'd1; tx_data0 = 8'h77; core_delay = 3; miso_base = 8'h40;
    snap();
    req = 2'b01;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (spi_rdy) ok = 1;
    end
    checkOutput("drop_first_rdy", 32'(ok), 32'd1);
    @(negedge clk);
    req = '0;
    tx_data0 = 8'h00;
    req_len0 = 4'd0;
    waitEnd(200, ok, d, e);
    checkOutput("drop_done", 32'(d), 32'h1);
    checkOutput("drop_rdy_count", 32'(n_rdy - s_rdy), 32'd2);
    checkOutput("drop_rxv", 32'(n_rxv0 - s_rxv0), 32'd2);
    checkOutput("drop_rx_data", 32'(last_rx), 32'h41);
    repeat (CS_GAP + 3) @(negedge clk);

    // Reset during the WAIT of byte 2 of 4; the core's late spi_done is stray.
    req_len1 = 4'd3; tx_data1 = 8'h99; core_delay = 5; miso_base = 8'h60;
    snap();
    req = 2'b10;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (rx_valid[1]) ok = 1;
    end
    checkOutput("rst_first_byte", 32'(ok), 32'd1);
    @(negedge clk);
    applyReset();
    snap();
    repeat (10) @(negedge clk);
    checkOutput("rst_stray_rxv", 32'((n_rxv0 - s_rxv0) + (n_rxv1 - s_rxv1)), 32'd0);
    checkOutput("rst_stray_done_err", 32'((n_done1 - s_done1) + (n_err - s_err)), 32'd0);
    checkOutput("rst_rx_data", 32'(rx_data), 32'h0);
    checkOutput("rst_idle_cs", 32'({grant, spi_cs_n}), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
